// File: rtl/branch_pred_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pred_pkg
//  Purpose  : Shared constants for the fetch-stage branch predictor:
//             default address width and 2-bit saturating counter encodings.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package branch_pred_pkg;

  // Default instruction address width (word addressed).
  localparam int ADDR = 32;

  // 2-bit saturating counter encodings; bit 1 set means "predict taken".
  localparam logic [1:0] CTR_SNT = 2'd0;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'd1;  // weakly not taken (reset value)
  localparam logic [1:0] CTR_WT  = 2'd2;  // weakly taken (allocation value)
  localparam logic [1:0] CTR_ST  = 2'd3;  // strongly taken

endpackage : branch_pred_pkg
`default_nettype wire

// File: rtl/branch_pred_sat_ctr2.sv
`default_nettype none
// ============================================================================
//  Module   : sat_ctr2
//  Purpose  : Combinational 2-bit saturating counter step. Increments toward
//             strongly-taken on a taken outcome, decrements toward
//             strongly-not-taken otherwise.
//  Ports    : i_ctr   - current counter value
//             i_taken - resolved branch outcome
//             o_ctr   - next counter value
//  Revision : 1.0 - initial release
// ============================================================================
module sat_ctr2
  import branch_pred_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule : sat_ctr2
`default_nettype wire

// File: rtl/branch_pred.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pred
//  Purpose  : Fetch-stage branch predictor and redirect generator. A
//             direct-mapped BTB with 2-bit counters gives a combinational
//             taken/target prediction for the fetch PC; resolved branches
//             train the table and a mispredict raises a registered redirect.
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             pc_i, stall_i        - fetch PC and fetch stall
//             pred_o, pred_addr_o  - combinational prediction and target
//             upd_*                - resolved-branch training interface
//             branch_o, branch_addr_o - registered redirect pulse/address
//  Revision : 1.0 - initial release
// ============================================================================
module branch_pred #(
  parameter int ADDR    = branch_pred_pkg::ADDR,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ADDR-1:0] pc_i,
  input  logic            stall_i,
  output logic            pred_o,
  output logic [ADDR-1:0] pred_addr_o,
  input  logic            upd_i,
  input  logic [ADDR-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [ADDR-1:0] upd_target_i,
  input  logic            upd_pred_i,
  input  logic [ADDR-1:0] upd_pred_addr_i,
  output logic            branch_o,
  output logic [ADDR-1:0] branch_addr_o
);

  import branch_pred_pkg::*;

  localparam int IDX = $clog2(ENTRIES);
  localparam int TAG = ADDR - IDX;

  // Table storage: flat arrays indexed by the low PC bits.
  logic            r_valid  [ENTRIES];
  logic [TAG-1:0]  r_tag    [ENTRIES];
  logic [ADDR-1:0] r_target [ENTRIES];
  logic [1:0]      r_ctr    [ENTRIES];

  logic            r_branch;
  logic [ADDR-1:0] r_branch_addr;

  // Lookup path.
  logic [IDX-1:0]  w_idx;
  logic            w_hit;

  assign w_idx       = pc_i[IDX-1:0];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == pc_i[ADDR-1:IDX]);
  assign pred_o      = w_hit & r_ctr[w_idx][1] & ~stall_i;
  assign pred_addr_o = pred_o ? r_target[w_idx] : '0;

  // Update path.
  logic [IDX-1:0]  w_uidx;
  logic [TAG-1:0]  w_utag;
  logic            w_uhit;
  logic [1:0]      w_ctr_next;
  logic            w_mis;
  logic [ADDR-1:0] w_redirect;

  assign w_uidx = upd_pc_i[IDX-1:0];
  assign w_utag = upd_pc_i[ADDR-1:IDX];
  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

  sat_ctr2 u_sat_ctr2 (
    .i_ctr   (r_ctr[w_uidx]),
    .i_taken (upd_taken_i),
    .o_ctr   (w_ctr_next)
  );

  // Wrong direction, or right "taken" direction with the wrong target.
  assign w_mis = upd_i &&
                 ((upd_taken_i != upd_pred_i) ||
                  (upd_taken_i && upd_pred_i && (upd_target_i != upd_pred_addr_i)));

  // Fall-through wraps naturally at the address width.
  assign w_redirect = upd_taken_i ? upd_target_i : (upd_pc_i + ADDR'(1));

  // Table writes land at the end of the update cycle, so a same-cycle lookup
  // at the same index still observes the previous contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_WNT;
      end
    end else if (upd_i) begin
      if (w_uhit) begin
        r_ctr[w_uidx] <= w_ctr_next;
        if (upd_taken_i) r_target[w_uidx] <= upd_target_i;
      end else if (upd_taken_i) begin
        // Allocate, evicting whatever aliased into this slot.
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= upd_target_i;
        r_ctr[w_uidx]    <= CTR_WT;
      end
    end
  end

  // Redirect register: one-cycle pulse per mispredict, address held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch      <= 1'b0;
      r_branch_addr <= '0;
    end else begin
      r_branch <= w_mis;
      if (w_mis) r_branch_addr <= w_redirect;
    end
  end

  assign branch_o      = r_branch;
  assign branch_addr_o = r_branch_addr;

endmodule : branch_pred
`default_nettype wire

// File: tb/tb_branch_pred.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_pred
//  Purpose  : Self-checking bench for branch_pred: directed scenarios plus
//             randomized traffic against a behavioural BTB model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_pred;

  localparam int ADDR    = 32;
  localparam int ENTRIES = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [ADDR-1:0] pc_i;
  logic            stall_i;
  logic            pred_o;
  logic [ADDR-1:0] pred_addr_o;
  logic            upd_i;
  logic [ADDR-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [ADDR-1:0] upd_target_i;
  logic            upd_pred_i;
  logic [ADDR-1:0] upd_pred_addr_i;
  logic            branch_o;
  logic [ADDR-1:0] branch_addr_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_pred #(.ADDR(ADDR), .ENTRIES(ENTRIES)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_i            (pc_i),
    .stall_i         (stall_i),
    .pred_o          (pred_o),
    .pred_addr_o     (pred_addr_o),
    .upd_i           (upd_i),
    .upd_pc_i        (upd_pc_i),
    .upd_taken_i     (upd_taken_i),
    .upd_target_i    (upd_target_i),
    .upd_pred_i      (upd_pred_i),
    .upd_pred_addr_i (upd_pred_addr_i),
    .branch_o        (branch_o),
    .branch_addr_o   (branch_addr_o)
  );

  // Behavioural model: table as plain arrays, counters as integers 0..3.
  bit        m_valid  [ENTRIES];
  logic [31:0] m_tag  [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int        m_ctr    [ENTRIES];
  bit        m_br;
  logic [31:0] m_br_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc % ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == pc / ENTRIES);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc, input bit stall);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2) && !stall;
  endfunction

  function automatic logic [31:0] m_pred_addr(input logic [31:0] pc, input bit stall);
    return m_pred(pc, stall) ? m_target[idx_of(pc)] : 32'd0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_br      = 1'b0;
    m_br_addr = 32'd0;
  endtask

  task automatic m_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                          input bit upred, input logic [31:0] upaddr);
    int  k;
    bit  mis;
    k   = idx_of(pc);
    mis = (taken != upred) || (taken && upred && tgt != upaddr);
    if (m_hit(pc)) begin
      if (taken) begin
        m_ctr[k]    = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
        m_target[k] = tgt;
      end else begin
        m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[k]  = 1'b1;
      m_tag[k]    = pc / ENTRIES;
      m_target[k] = tgt;
      m_ctr[k]    = 2;
    end
    m_br = mis;
    if (mis) m_br_addr = taken ? tgt : pc + 32'd1;
  endtask

  bit m_live = 1'b0;  // lookup checks are meaningful once reset has been applied

  // One clock cycle: drive at negedge, check lookup mid-cycle, advance model
  // at the posedge, then check the redirect register just after the edge.
  task automatic cyc(input bit rst, input logic [31:0] pc, input bit stall,
                     input bit upd, input logic [31:0] upc, input bit taken,
                     input logic [31:0] tgt, input bit upred, input logic [31:0] upaddr);
    @(negedge clk);
    reset = rst; pc_i = pc; stall_i = stall;
    upd_i = upd; upd_pc_i = upc; upd_taken_i = taken; upd_target_i = tgt;
    upd_pred_i = upred; upd_pred_addr_i = upaddr;
    #1;
    if (m_live) begin
      check("pred", 64'(pred_o), 64'(m_pred(pc, stall)));
      check("pred_addr", 64'(pred_addr_o), 64'(m_pred_addr(pc, stall)));
    end
    @(posedge clk);
    if (rst) begin
      m_reset();
      m_live = 1'b1;
    end else if (upd) begin
      m_update(upc, taken, tgt, upred, upaddr);
    end else begin
      m_br = 1'b0;
    end
    #1;
    if (m_live) begin
      check("branch", 64'(branch_o), 64'(m_br));
      check("branch_addr", 64'(branch_addr_o), 64'(m_br_addr));
    end
  endtask

  // Combinational lookup probe with explicit expected values; no clock edge.
  task automatic look(input logic [31:0] pc, input bit stall, input bit ep, input logic [31:0] ea);
    @(negedge clk);
    reset = 1'b0; pc_i = pc; stall_i = stall; upd_i = 1'b0;
    #1;
    check("look_pred", 64'(pred_o), 64'(ep));
    check("look_addr", 64'(pred_addr_o), 64'(ea));
  endtask

  task automatic idle(input logic [31:0] pc);
    cyc(1'b0, pc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic resolve(input logic [31:0] upc, input bit taken, input logic [31:0] tgt,
                         input bit upred, input logic [31:0] upaddr);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, upc, taken, tgt, upred, upaddr);
  endtask

  initial begin
    reset = 1'b1; pc_i = '0; stall_i = 1'b0; upd_i = 1'b0; upd_pc_i = '0;
    upd_taken_i = 1'b0; upd_target_i = '0; upd_pred_i = 1'b0; upd_pred_addr_i = '0;

    // Reset state.
    cyc(1'b1, 32'd5, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b1, 32'd5, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(32'd5);
    check("rst_branch", 64'(branch_o), 64'd0);
    look(32'd5, 1'b0, 1'b0, 32'd0);

    // First taken resolution allocates and redirects.
    resolve(32'd5, 1'b1, 32'h40, 1'b0, 32'd0);
    check("alloc_branch", 64'(branch_o), 64'd1);
    check("alloc_baddr", 64'(branch_addr_o), 64'h40);
    look(32'd5, 1'b0, 1'b1, 32'h40);
    look(32'd5, 1'b1, 1'b0, 32'd0);

    // Saturate to 3, one not-taken still predicts, second does not.
    repeat (3) resolve(32'd5, 1'b1, 32'h40, 1'b1, 32'h40);
    check("sat_nobranch", 64'(branch_o), 64'd0);
    resolve(32'd5, 1'b0, 32'd0, 1'b1, 32'h40);
    check("nt_baddr", 64'(branch_addr_o), 64'd6);
    look(32'd5, 1'b0, 1'b1, 32'h40);
    resolve(32'd5, 1'b0, 32'd0, 1'b1, 32'h40);
    look(32'd5, 1'b0, 1'b0, 32'd0);

    // Aliasing: PC 21 shares index 5 and evicts PC 5.
    resolve(32'd5, 1'b1, 32'h40, 1'b0, 32'd0);
    resolve(32'd21, 1'b1, 32'h80, 1'b0, 32'd0);
    look(32'd5, 1'b0, 1'b0, 32'd0);
    look(32'd21, 1'b0, 1'b1, 32'h80);

    // Right direction, wrong target; then fully correct.
    resolve(32'd5, 1'b1, 32'h40, 1'b0, 32'd0);
    resolve(32'd5, 1'b1, 32'h44, 1'b1, 32'h40);
    check("tgt_branch", 64'(branch_o), 64'd1);
    check("tgt_baddr", 64'(branch_addr_o), 64'h44);
    look(32'd5, 1'b0, 1'b1, 32'h44);
    resolve(32'd5, 1'b1, 32'h44, 1'b1, 32'h44);
    check("ok_nobranch", 64'(branch_o), 64'd0);
    check("ok_hold_addr", 64'(branch_addr_o), 64'h44);

    // Same-cycle lookup and eviction at index 5: lookup sees the old entry.
    cyc(1'b0, 32'd5, 1'b0, 1'b1, 32'd21, 1'b1, 32'h90, 1'b0, 32'd0);
    look(32'd5, 1'b0, 1'b0, 32'd0);
    look(32'd21, 1'b0, 1'b1, 32'h90);

    // Fall-through wraps at the top of the address space.
    resolve(32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1, 32'h10);
    check("wrap_baddr", 64'(branch_addr_o), 64'd0);

    // Reset wins over a simultaneous update.
    cyc(1'b1, 32'd7, 1'b0, 1'b1, 32'd7, 1'b1, 32'h100, 1'b0, 32'd0);
    check("rstupd_branch", 64'(branch_o), 64'd0);
    check("rstupd_baddr", 64'(branch_addr_o), 64'd0);
    look(32'd7, 1'b0, 1'b0, 32'd0);
    look(32'd21, 1'b0, 1'b0, 32'd0);

    // Randomized traffic over a small PC window to force hits and aliasing.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc, upc, tgt, upaddr;
      bit rst, stall, upd, taken, upred;
      pc    = 32'($urandom_range(0, 47));
      upc   = ($urandom_range(0, 99) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 47));
      stall = ($urandom_range(0, 3) == 0);
      upd   = ($urandom_range(0, 3) != 0);
      taken = $urandom_range(0, 1) == 1;
      tgt   = 32'h100 + 32'($urandom_range(0, 3));
      rst   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1) begin
        upred  = m_pred(upc, 1'b0);
        upaddr = m_pred_addr(upc, 1'b0);
      end else begin
        upred  = $urandom_range(0, 1) == 1;
        upaddr = 32'h100 + 32'($urandom_range(0, 3));
      end
      cyc(rst, pc, stall, upd, upc, taken, tgt, upred, upaddr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_branch_pred
`default_nettype wire
